hilo_muldiv_ctrl: RTL and testbench
===================================

Name: hilo_muldiv_ctrl

Overview:
- Sequencing controller for the HI/LO register pair.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the EX stage and runs an internal multi-cycle multiplier.
- Hands division to an external multi-cycle divider through a start/done handshake.
- Stalls the pipeline while busy and issues exactly one HI/LO write per committed instruction; flushes cancel in-flight work.

Parameters:
- MUL_CYCLES, 2, multiplier latency in cycles from issue to result (legal 1..8).
- DIV_SIGNED_DEFAULT, 1, value of div_signed when no divide is in flight.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, synchronous, active-low
- op_valid  input  1  EX-stage instruction valid
- op_code  input  3  0=none, 1=MULT, 2=MULTU, 3=DIV, 4=DIVU, 5=MTHI, 6=MTLO, 7=reserved (MADD/MSUB select, see Optional Feature)
- op_sub  input  1  with op_code 7: 0=MADD, 1=MSUB; ignored otherwise
- src_a  input  32  rs value
- src_b  input  32  rt value
- flush  input  1  exception/flush for the EX instruction
- stall_i  input  1  downstream stall; instruction cannot leave EX
- hilo_i  input  64  current {HI,LO}
- div_done  input  1  divider result valid, one-cycle pulse
- div_result  input  64  {remainder, quotient}
- div_start  output  1  one-cycle divider start pulse
- div_cancel  output  1  one-cycle divider abort pulse
- div_signed  output  1  signed divide select
- div_a  output  32  dividend (registered)
- div_b  output  32  divisor (registered)
- stall_o  output  1  hold IF/ID/EX
- hilo_we  output  1  HI/LO write enable, one-cycle pulse
- hilo_wdata  output  64  {HI,LO} write value
- busy  output  1  state != IDLE

Behaviour:
- Reset (rst==0 at a clk edge): state=IDLE, counter=0; all outputs 0 except div_signed=DIV_SIGNED_DEFAULT. Reset mid-operation aborts with no write and no div_cancel.
- IDLE, op_valid=1, flush=0:
  - MULT/MULTU: capture operands and signedness; counter=MUL_CYCLES-1; go MUL_BUSY; stall_o=1 combinationally in the issue cycle.
  - DIV/DIVU, src_b!=0: div_start=1, div_a/div_b/div_signed registered; go DIV_BUSY; stall_o=1.
  - DIV/DIVU, src_b==0: no divider start; HI/LO left unchanged; go DONE with write suppressed; stall_o=1 in the issue cycle.
  - MTHI/MTLO: result {src_a, hilo_i[31:0]} or {hilo_i[63:32], src_a}; go DONE; stall_o=1 in the issue cycle.
  - op_code 0, or any op with flush=1: remain IDLE.
- MUL_BUSY: stall_o=1; counter decrements each cycle; at counter==0 the 64-bit product (signed or unsigned per captured op) is registered; go DONE.
- DIV_BUSY: stall_o=1; on div_done, register div_result as {HI=remainder, LO=quotient}; go DONE.
- DONE:
  - stall_o=0.
  - hilo_we=1 only in the first DONE cycle, and only if a write is pending.
  - While stall_i=1, stay in DONE with no further hilo_we.
  - When stall_i=0, go IDLE; inputs are ignored in DONE.
- flush in MUL_BUSY or DIV_BUSY: go IDLE next cycle with no write; in DIV_BUSY, pulse div_cancel for one cycle. flush in DONE has no effect, since the write has already occurred.
- flush and div_done in the same cycle: flush wins, no write.
- Sign rules: MULT/DIV sign-extend operands; MULTU/DIVU zero-extend. Products are exact 64-bit.

Optional Feature:
- Macro HILO_MADD_EN.
- Defined: op_code 7 is accepted. It runs as MULT for MUL_CYCLES, then computes hilo_wdata = hilo_i + product (op_sub=0) or hilo_i - product (op_sub=1). hilo_i is sampled in the cycle before DONE. Arithmetic is 64-bit modulo 2^64.
- Not defined: op_code 7 is treated as none; the controller stays IDLE with no stall.

Test Plan:
- Reset: hold rst=0 for 3 cycles mid-MUL_BUSY -> stall_o=0, hilo_we=0, busy=0, div_start=0.
- MULT: a=0xFFFFFFFE, b=3, MUL_CYCLES=2 -> stall_o high for 3 cycles, then hilo_we pulse once with 0xFFFFFFFF_FFFFFFFA. MULTU with the same operands -> 0x00000002_FFFFFFFA.
- DIV: a=-7, b=2 -> div_start one pulse with div_signed=1. div_done after 10 cycles with {0xFFFFFFFF,0xFFFFFFFD} -> hilo_we with that value; stall_o drops in the DONE cycle.
- Divide by zero: DIVU b=0 -> no div_start, no hilo_we, stall_o high 1 cycle.
- MTHI: a=0x12345678, hilo_i=0xAAAAAAAA_BBBBBBBB, with stall_i=1 for 2 cycles in DONE -> a single hilo_we with 0x12345678_BBBBBBBB; state holds DONE until stall_i=0.
- Flush in DIV_BUSY coincident with div_done -> div_cancel pulse, no hilo_we, IDLE next cycle. With HILO_MADD_EN, MSUB hilo_i=0, a=b=1 -> 0xFFFFFFFF_FFFFFFFF.

Source files
------------

// File: rtl/hilo_muldiv_ctrl.sv
// ----------------------------------------------------------------------------
// hilo_muldiv_ctrl
// Sequencing controller for the HI/LO register pair. Accepts MULT/MULTU/DIV/
// DIVU/MTHI/MTLO from EX, runs an internal multi-cycle multiplier, hands
// divides to an external divider via start/done, stalls the pipeline while
// busy and issues exactly one HI/LO write per committed instruction.
//
// Optional feature: define HILO_MADD_EN to accept op_code 7 (MADD/MSUB,
// selected by op_sub). Without it op_code 7 is treated as "none".
//
// Ports:
//   clk, rst            clock (rising edge), synchronous active-low reset
//   op_valid/op_code    EX instruction valid and operation select
//   op_sub              MADD(0)/MSUB(1) select for op_code 7
//   src_a, src_b        rs / rt operand values
//   flush               cancel the EX instruction / in-flight work
//   stall_i             downstream stall, instruction cannot leave EX
//   hilo_i              current {HI,LO}
//   div_done/result     divider completion pulse and {rem, quot}
//   div_start/cancel    divider start / abort pulses
//   div_signed/a/b      divider sign select and registered operands
//   stall_o             hold IF/ID/EX (combinational in the issue cycle)
//   hilo_we/wdata       one-cycle HI/LO write enable and value
//   busy                controller not idle
// ----------------------------------------------------------------------------
module hilo_muldiv_ctrl #(
    parameter int unsigned MUL_CYCLES         = 2,
    parameter bit          DIV_SIGNED_DEFAULT = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    input  logic [2:0]  op_code,
    input  logic        op_sub,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    input  logic        stall_i,
    input  logic [63:0] hilo_i,
    input  logic        div_done,
    input  logic [63:0] div_result,
    output logic        div_start,
    output logic        div_cancel,
    output logic        div_signed,
    output logic [31:0] div_a,
    output logic [31:0] div_b,
    output logic        stall_o,
    output logic        hilo_we,
    output logic [63:0] hilo_wdata,
    output logic        busy
);

    localparam int unsigned CNT_W = 3;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MUL_CYCLES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;
`ifdef HILO_MADD_EN
    localparam logic [2:0] OP_MADD  = 3'd7;
`endif

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      a_q, a_d, b_q, b_d;
    logic             sgn_q, sgn_d;
    logic             div_start_q, div_start_d;
    logic             div_cancel_q, div_cancel_d;
    logic             div_signed_q, div_signed_d;
    logic [31:0]      div_a_q, div_a_d, div_b_q, div_b_d;
    logic             hilo_we_q, hilo_we_d;
    logic [63:0]      hilo_wdata_q, hilo_wdata_d;

    logic [63:0]      ext_a, ext_b, prod, mul_result;

    // Operands widened to 64 bits; the low 64 bits of the product are exact
    // for both signed and unsigned interpretations.
    assign ext_a = sgn_q ? {{32{a_q[31]}}, a_q} : {32'b0, a_q};
    assign ext_b = sgn_q ? {{32{b_q[31]}}, b_q} : {32'b0, b_q};
    assign prod  = ext_a * ext_b;

`ifdef HILO_MADD_EN
    logic acc_q, acc_d;
    logic sub_q, sub_d;

    // Accumulate into the HI/LO value seen in the last multiply cycle.
    always_comb begin
        mul_result = prod;
        if (acc_q) begin
            mul_result = sub_q ? (hilo_i - prod) : (hilo_i + prod);
        end
    end
`else
    logic unused_op_sub;
    assign unused_op_sub = op_sub;
    assign mul_result    = prod;
`endif

    // Next-state, datapath capture and stall decode.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        a_d          = a_q;
        b_d          = b_q;
        sgn_d        = sgn_q;
        div_start_d  = 1'b0;
        div_cancel_d = 1'b0;
        div_signed_d = div_signed_q;
        div_a_d      = div_a_q;
        div_b_d      = div_b_q;
        hilo_we_d    = 1'b0;
        hilo_wdata_d = hilo_wdata_q;
        stall_o      = 1'b0;
`ifdef HILO_MADD_EN
        acc_d        = acc_q;
        sub_d        = sub_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (rst && op_valid && !flush) begin
                    case (op_code)
                        OP_MULT, OP_MULTU: begin
                            stall_o = 1'b1;
                            a_d     = src_a;
                            b_d     = src_b;
                            sgn_d   = (op_code == OP_MULT);
                            cnt_d   = CNT_INIT;
                            state_d = S_MUL;
`ifdef HILO_MADD_EN
                            acc_d   = 1'b0;
`endif
                        end
`ifdef HILO_MADD_EN
                        OP_MADD: begin
                            stall_o = 1'b1;
                            a_d     = src_a;
                            b_d     = src_b;
                            sgn_d   = 1'b1;
                            cnt_d   = CNT_INIT;
                            acc_d   = 1'b1;
                            sub_d   = op_sub;
                            state_d = S_MUL;
                        end
`endif
                        OP_DIV, OP_DIVU: begin
                            stall_o = 1'b1;
                            if (src_b != 32'd0) begin
                                div_start_d  = 1'b1;
                                div_a_d      = src_a;
                                div_b_d      = src_b;
                                div_signed_d = (op_code == OP_DIV);
                                state_d      = S_DIV;
                            end else begin
                                // Divide by zero: HI/LO left untouched.
                                state_d = S_DONE;
                            end
                        end
                        OP_MTHI: begin
                            stall_o      = 1'b1;
                            hilo_we_d    = 1'b1;
                            hilo_wdata_d = {src_a, hilo_i[31:0]};
                            state_d      = S_DONE;
                        end
                        OP_MTLO: begin
                            stall_o      = 1'b1;
                            hilo_we_d    = 1'b1;
                            hilo_wdata_d = {hilo_i[63:32], src_a};
                            state_d      = S_DONE;
                        end
                        default: ;
                    endcase
                end
            end

            S_MUL: begin
                stall_o = 1'b1;
                if (flush) begin
                    state_d = S_IDLE;
                end else if (cnt_q == '0) begin
                    hilo_we_d    = 1'b1;
                    hilo_wdata_d = mul_result;
                    state_d      = S_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            S_DIV: begin
                stall_o = 1'b1;
                // Flush takes priority over a coincident div_done.
                if (flush) begin
                    div_cancel_d = 1'b1;
                    div_signed_d = DIV_SIGNED_DEFAULT;
                    state_d      = S_IDLE;
                end else if (div_done) begin
                    hilo_we_d    = 1'b1;
                    hilo_wdata_d = div_result;
                    div_signed_d = DIV_SIGNED_DEFAULT;
                    state_d      = S_DONE;
                end
            end

            S_DONE: begin
                if (!stall_i) begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            a_q          <= '0;
            b_q          <= '0;
            sgn_q        <= 1'b0;
            div_start_q  <= 1'b0;
            div_cancel_q <= 1'b0;
            div_signed_q <= DIV_SIGNED_DEFAULT;
            div_a_q      <= '0;
            div_b_q      <= '0;
            hilo_we_q    <= 1'b0;
            hilo_wdata_q <= '0;
`ifdef HILO_MADD_EN
            acc_q        <= 1'b0;
            sub_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            a_q          <= a_d;
            b_q          <= b_d;
            sgn_q        <= sgn_d;
            div_start_q  <= div_start_d;
            div_cancel_q <= div_cancel_d;
            div_signed_q <= div_signed_d;
            div_a_q      <= div_a_d;
            div_b_q      <= div_b_d;
            hilo_we_q    <= hilo_we_d;
            hilo_wdata_q <= hilo_wdata_d;
`ifdef HILO_MADD_EN
            acc_q        <= acc_d;
            sub_q        <= sub_d;
`endif
        end
    end

    assign div_start  = div_start_q;
    assign div_cancel = div_cancel_q;
    assign div_signed = div_signed_q;
    assign div_a      = div_a_q;
    assign div_b      = div_b_q;
    assign hilo_we    = hilo_we_q;
    assign hilo_wdata = hilo_wdata_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// ----------------------------------------------------------------------------
// tb_hilo_muldiv_ctrl
// Directed bench for hilo_muldiv_ctrl. Each scenario states, cycle by cycle,
// what the outputs must be; a single compare process checks them on the
// falling edge. Result values come from plain arithmetic models, and a few
// hand-computed literals pin those models.
// ----------------------------------------------------------------------------
module tb_hilo_muldiv_ctrl;

    localparam int unsigned MUL_CYCLES = 2;
    localparam bit          DIV_DEF    = 1'b1;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid;
    logic [2:0]  op_code;
    logic        op_sub;
    logic [31:0] src_a, src_b;
    logic        flush, stall_i;
    logic [63:0] hilo_i;
    logic        div_done;
    logic [63:0] div_result;
    logic        div_start, div_cancel, div_signed;
    logic [31:0] div_a, div_b;
    logic        stall_o, hilo_we, busy;
    logic [63:0] hilo_wdata;

    hilo_muldiv_ctrl #(
        .MUL_CYCLES         (MUL_CYCLES),
        .DIV_SIGNED_DEFAULT (DIV_DEF)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .op_valid   (op_valid),
        .op_code    (op_code),
        .op_sub     (op_sub),
        .src_a      (src_a),
        .src_b      (src_b),
        .flush      (flush),
        .stall_i    (stall_i),
        .hilo_i     (hilo_i),
        .div_done   (div_done),
        .div_result (div_result),
        .div_start  (div_start),
        .div_cancel (div_cancel),
        .div_signed (div_signed),
        .div_a      (div_a),
        .div_b      (div_b),
        .stall_o    (stall_o),
        .hilo_we    (hilo_we),
        .hilo_wdata (hilo_wdata),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Expected outputs for the current cycle.
    logic        chk_en = 1'b0;
    logic        exp_stall, exp_busy, exp_we, exp_start, exp_cancel, exp_signed;
    logic [63:0] exp_wdata;
    logic [31:0] exp_div_a, exp_div_b;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Signed/unsigned 32x32 product, exact in 64 bits.
    function automatic logic [63:0] m_mul(input logic [31:0] a, input logic [31:0] b, input bit s);
        longint          sa, sb;
        longint unsigned ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = 64'(a);
        ub = 64'(b);
        return s ? 64'(sa * sb) : 64'(ua * ub);
    endfunction

    function automatic logic [63:0] m_mt(input bit hi, input logic [31:0] a, input logic [63:0] hl);
        return hi ? {a, hl[31:0]} : {hl[63:32], a};
    endfunction

    // Single compare process.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("stall_o", 64'(stall_o), 64'(exp_stall));
            chk("busy", 64'(busy), 64'(exp_busy));
            chk("hilo_we", 64'(hilo_we), 64'(exp_we));
            chk("div_start", 64'(div_start), 64'(exp_start));
            chk("div_cancel", 64'(div_cancel), 64'(exp_cancel));
            chk("div_signed", 64'(div_signed), 64'(exp_signed));
            if (exp_we) chk("hilo_wdata", hilo_wdata, exp_wdata);
            if (exp_start) begin
                chk("div_a", 64'(div_a), 64'(exp_div_a));
                chk("div_b", 64'(div_b), 64'(exp_div_b));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Like step, but also pins hilo_wdata to a hand-computed literal.
    task automatic step_lit(input string name, input logic [63:0] lit);
        @(negedge clk);
        #1;
        chk(name, hilo_wdata, lit);
        @(posedge clk);
        #1;
    endtask

    task automatic exp_idle();
        exp_stall  = 1'b0;
        exp_busy   = 1'b0;
        exp_we     = 1'b0;
        exp_start  = 1'b0;
        exp_cancel = 1'b0;
        exp_signed = DIV_DEF;
        exp_wdata  = '0;
    endtask

    // Multiply-class op: stall for issue + MUL_CYCLES, then one write.
    task automatic do_mul(input logic [2:0] code, input logic sub, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] hl, input logic [63:0] lit);
        logic [63:0] p;
        op_valid = 1'b1; op_code = code; op_sub = sub; src_a = a; src_b = b; hilo_i = hl;
        exp_idle(); exp_stall = 1'b1;
        step();
        for (int i = 0; i < int'(MUL_CYCLES); i++) begin
            exp_stall = 1'b1; exp_busy = 1'b1;
            step();
        end
        op_valid = 1'b0;
        p = m_mul(a, b, code != 3'd2);
        exp_stall = 1'b0; exp_busy = 1'b1; exp_we = 1'b1;
        exp_wdata = (code == 3'd7) ? (sub ? hl - p : hl + p) : p;
        step_lit("mul_literal", lit);
        exp_idle();
        step();
    endtask

    // Divide with the divider answering wait_n cycles after div_start.
    task automatic do_div(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b,
                          input int wait_n, input logic [63:0] res);
        op_valid = 1'b1; op_code = code; src_a = a; src_b = b;
        exp_idle(); exp_stall = 1'b1;
        step();
        exp_busy = 1'b1; exp_start = 1'b1; exp_signed = (code == 3'd3);
        exp_div_a = a; exp_div_b = b;
        step();
        exp_start = 1'b0;
        for (int i = 1; i < wait_n; i++) step();
        div_done = 1'b1; div_result = res;
        step();
        div_done = 1'b0; op_valid = 1'b0;
        exp_stall = 1'b0; exp_we = 1'b1; exp_wdata = res; exp_signed = DIV_DEF;
        step_lit("div_literal", res);
        exp_idle();
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; op_valid = 1'b0; op_code = '0; op_sub = 1'b0;
        src_a = '0; src_b = '0; flush = 1'b0; stall_i = 1'b0;
        hilo_i = '0; div_done = 1'b0; div_result = '0;
        exp_idle(); exp_div_a = '0; exp_div_b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b1;
        step();
        rst = 1'b1;
        step();

        // MULT / MULTU on the same operands.
        do_mul(3'd1, 1'b0, 32'hFFFF_FFFE, 32'd3, '0, 64'hFFFF_FFFF_FFFF_FFFA);
        do_mul(3'd2, 1'b0, 32'hFFFF_FFFE, 32'd3, '0, 64'h0000_0002_FFFF_FFFA);
        do_mul(3'd1, 1'b0, 32'h8000_0000, 32'h8000_0000, '0, 64'h4000_0000_0000_0000);

        // Signed divide, result after 10 cycles; then an unsigned one.
        do_div(3'd3, 32'hFFFF_FFF9, 32'd2, 10, 64'hFFFF_FFFF_FFFF_FFFD);
        do_div(3'd4, 32'd100, 32'd7, 3, 64'h0000_0002_0000_000E);

        // DIVU by zero: one stall cycle, no start, no write.
        op_valid = 1'b1; op_code = 3'd4; src_a = 32'd5; src_b = 32'd0;
        exp_idle(); exp_stall = 1'b1;
        step();
        op_valid = 1'b0;
        exp_stall = 1'b0; exp_busy = 1'b1;
        step();
        exp_idle();
        step();

        // MTHI with downstream stall held two cycles in DONE.
        op_valid = 1'b1; op_code = 3'd5; src_a = 32'h1234_5678; hilo_i = 64'hAAAA_AAAA_BBBB_BBBB;
        exp_idle(); exp_stall = 1'b1;
        step();
        op_valid = 1'b0; stall_i = 1'b1;
        exp_stall = 1'b0; exp_busy = 1'b1; exp_we = 1'b1;
        exp_wdata = m_mt(1'b1, 32'h1234_5678, 64'hAAAA_AAAA_BBBB_BBBB);
        step_lit("mthi_literal", 64'h1234_5678_BBBB_BBBB);
        exp_we = 1'b0;
        step();
        stall_i = 1'b0;
        step();
        exp_idle();
        step();

        // MTLO without downstream stall.
        op_valid = 1'b1; op_code = 3'd6; src_a = 32'hCAFE_F00D; hilo_i = 64'h1111_2222_3333_4444;
        exp_idle(); exp_stall = 1'b1;
        step();
        op_valid = 1'b0;
        exp_stall = 1'b0; exp_busy = 1'b1; exp_we = 1'b1;
        exp_wdata = m_mt(1'b0, 32'hCAFE_F00D, 64'h1111_2222_3333_4444);
        step_lit("mtlo_literal", 64'h1111_2222_CAFE_F00D);
        exp_idle();
        step();

        // Flush in DIV_BUSY coincident with div_done.
        op_valid = 1'b1; op_code = 3'd4; src_a = 32'd100; src_b = 32'd7;
        exp_idle(); exp_stall = 1'b1;
        step();
        exp_busy = 1'b1; exp_start = 1'b1; exp_signed = 1'b0;
        exp_div_a = 32'd100; exp_div_b = 32'd7;
        step();
        exp_start = 1'b0;
        flush = 1'b1; div_done = 1'b1; div_result = 64'h0000_0002_0000_000E;
        step();
        flush = 1'b0; div_done = 1'b0; op_valid = 1'b0;
        exp_idle(); exp_cancel = 1'b1;
        step();
        exp_idle();
        step();

        // Flush in MUL_BUSY: no write, no cancel.
        op_valid = 1'b1; op_code = 3'd1; src_a = 32'd9; src_b = 32'd9;
        exp_idle(); exp_stall = 1'b1;
        step();
        flush = 1'b1;
        exp_busy = 1'b1;
        step();
        flush = 1'b0; op_valid = 1'b0;
        exp_idle();
        step();
        step();

        // Flush on the issue cycle and op_code 0: never leave IDLE.
        op_valid = 1'b1; op_code = 3'd1; flush = 1'b1;
        exp_idle();
        step();
        flush = 1'b0; op_code = 3'd0;
        step();
        op_valid = 1'b0;
        step();

`ifdef HILO_MADD_EN
        do_mul(3'd7, 1'b1, 32'd1, 32'd1, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF);
        do_mul(3'd7, 1'b0, 32'hFFFF_FFFF, 32'd2, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF);
`else
        op_valid = 1'b1; op_code = 3'd7; op_sub = 1'b1; src_a = 32'd1; src_b = 32'd1;
        exp_idle();
        step();
        step();
        op_valid = 1'b0;
        step();
`endif

        // Synchronous reset held 3 cycles in the middle of a multiply.
        op_valid = 1'b1; op_code = 3'd1; src_a = 32'd3; src_b = 32'd4;
        exp_idle(); exp_stall = 1'b1;
        step();
        exp_busy = 1'b1;
        step();
        chk_en = 1'b0;
        rst = 1'b0; op_valid = 1'b0;
        step();
        chk_en = 1'b1;
        exp_idle();
        step();
        step();
        rst = 1'b1;
        step();
        step();
        step();

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
